seq_event_log: RTL and testbench

Downstream consumer of the sequence detector's `dout_mealy` / `dout_moore` pulses.

- Counts detections on each output and checks that every Mealy pulse is followed by a Moore pulse one cycle later.
- Timestamps each Mealy detection and buffers the timestamps in a small first-word-fall-through FIFO, drained over a valid/ready handshake.
- Sits between the detector and any host/readout logic. Its two detection inputs wire directly to the detector's outputs.

---
 rtl/seq_event_log_pkg.sv | 14 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/seq_event_log.sv | 93 +++++++++
 tb/tb_seq_event_log.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_event_log_pkg.sv
// Shared definitions for the detection event logger: parameter defaults and
// the pairing FSM state encoding.
package seq_event_log_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        IDLE       = 1'b0,
        WAIT_MOORE = 1'b1
    } pair_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a drop indication for pushes
// refused while full. Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Head is forced to zero when empty so stale storage never shows after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately left unreset; the pointers alone define
    // which entries are live, which keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/seq_event_log.sv
// Detection logger: counts Mealy/Moore pulses, checks that each Mealy pulse is
// followed by a Moore pulse one cycle later, and queues Mealy timestamps.
module seq_event_log
    import seq_event_log_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dout_mealy,
    input  logic             dout_moore,
    input  logic             clr,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [CNT_W-1:0] mealy_cnt,
    output logic [CNT_W-1:0] moore_cnt,
    output logic             mismatch,
    output logic             overflow
);

    logic [TS_W-1:0] ts;
    pair_state_e     state_q;
    pair_state_e     state_d;
    logic            mismatch_set;
    logic            fifo_empty;
    logic            fifo_drop;
    logic            unused_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts        <= '0;
            mealy_cnt <= '0;
            moore_cnt <= '0;
            state_q   <= IDLE;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
        end else if (clr) begin
            ts        <= '0;
            mealy_cnt <= '0;
            moore_cnt <= '0;
            state_q   <= IDLE;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ts      <= ts + TS_W'(1);
            state_q <= state_d;
            if (dout_mealy && (mealy_cnt != '1)) mealy_cnt <= mealy_cnt + CNT_W'(1);
            if (dout_moore && (moore_cnt != '1)) moore_cnt <= moore_cnt + CNT_W'(1);
            if (mismatch_set) mismatch <= 1'b1;
            if (fifo_drop)    overflow <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        mismatch_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dout_mealy) state_d = WAIT_MOORE;
                if (dout_moore) mismatch_set = 1'b1;
            end
            WAIT_MOORE: begin
                if (!dout_moore) mismatch_set = 1'b1;
                state_d = dout_mealy ? WAIT_MOORE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (clr),
        .push      (dout_mealy),
        .push_data (ts),
        .full      (unused_full),
        .pop       (ev_ready),
        .pop_data  (ev_ts),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_seq_event_log.sv
// Randomised and directed bench for seq_event_log with a queue-based reference
// model; a separate monitor compares DUT outputs against the model every cycle.
module tb_seq_event_log;

    localparam int TS_W   = 16;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int TS_MOD = 1 << TS_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             dout_mealy;
    logic             dout_moore;
    logic             clr;
    logic             ev_valid;
    logic             ev_ready;
    logic [TS_W-1:0]  ev_ts;
    logic [CNT_W-1:0] mealy_cnt;
    logic [CNT_W-1:0] moore_cnt;
    logic             mismatch;
    logic             overflow;

    // Small-timestamp instance used only for the wrap check.
    logic             rst_w;
    logic             w_mealy;
    logic             w_moore;
    logic             w_clr;
    logic             w_valid;
    logic             w_ready;
    logic [3:0]       w_ts;
    logic [CNT_W-1:0] w_mcnt;
    logic [CNT_W-1:0] w_ocnt;
    logic             w_mis;
    logic             w_ovf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_ts;
    int          m_mc;
    int          m_oc;
    bit          m_mis;
    bit          m_ovf;
    bit          m_prev;
    int          q[$];
    bit          mon_en;

    seq_event_log #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .dout_mealy (dout_mealy),
        .dout_moore (dout_moore),
        .clr        (clr),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_ts      (ev_ts),
        .mealy_cnt  (mealy_cnt),
        .moore_cnt  (moore_cnt),
        .mismatch   (mismatch),
        .overflow   (overflow)
    );

    seq_event_log #(.TS_W(4), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut_w (
        .clk        (clk),
        .rst        (rst_w),
        .dout_mealy (w_mealy),
        .dout_moore (w_moore),
        .clr        (w_clr),
        .ev_valid   (w_valid),
        .ev_ready   (w_ready),
        .ev_ts      (w_ts),
        .mealy_cnt  (w_mcnt),
        .moore_cnt  (w_ocnt),
        .mismatch   (w_mis),
        .overflow   (w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ts   = 0;
        m_mc   = 0;
        m_oc   = 0;
        m_mis  = 1'b0;
        m_ovf  = 1'b0;
        m_prev = 1'b0;
        q.delete();
    endtask

    // Applies one sampled cycle of inputs. Pops are taken by the monitor just
    // before the edge, so the queue size here already reflects a same-cycle pop.
    task automatic model_update(input bit m, input bit mo, input bit c);
        if (c) begin
            model_reset();
            return;
        end
        if (mo != m_prev) m_mis = 1'b1;
        m_prev = m;
        if (m && m_mc < CMAX) m_mc++;
        if (mo && m_oc < CMAX) m_oc++;
        if (m) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back(m_ts);
        end
        m_ts = (m_ts + 1) % TS_MOD;
    endtask

    task automatic step(input bit m, input bit mo, input bit rdy, input bit c);
        dout_mealy = m;
        dout_moore = mo;
        ev_ready   = rdy;
        clr        = c;
        @(posedge clk);
        model_update(m, mo, c);
        #1;
    endtask

    task automatic idle_until(input int target, input bit rdy);
        for (int n = 0; n < TS_MOD && m_ts != target; n++) step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Monitor: compares against the model and consumes an entry on each handshake.
    always @(negedge clk) begin
        if (rst && mon_en) begin
            check("ev_valid", ev_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("ev_ts", ev_ts, q[0]);
                if (ev_ready) void'(q.pop_front());
            end
            check("mealy_cnt", mealy_cnt, m_mc);
            check("moore_cnt", moore_cnt, m_oc);
            check("mismatch", mismatch, m_mis);
            check("overflow", overflow, m_ovf);
        end
    end

    initial begin
        rst = 1'b0; rst_w = 1'b0;
        dout_mealy = 1'b0; dout_moore = 1'b0; clr = 1'b0; ev_ready = 1'b0;
        w_mealy = 1'b0; w_moore = 1'b0; w_clr = 1'b0; w_ready = 1'b0;
        mon_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ev_valid, 0);
        check("rst_ts", ev_ts, 0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Reset and single pair
        idle_until(5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_mealy_cnt", mealy_cnt, 1);
        check("t1_moore_cnt", moore_cnt, 1);
        check("t1_mismatch", mismatch, 0);
        check("t1_valid", ev_valid, 1);
        check("t1_ev_ts", ev_ts, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_popped", ev_valid, 0);

        // Overlapping detections
        idle_until(10, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_mismatch", mismatch, 0);
        check("t2_head", ev_ts, 10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_next", ev_ts, 11);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_empty", ev_valid, 0);

        // Pairing errors
        idle_until(20, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_missing_moore", mismatch, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t3_clr", mismatch, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_lone_moore", mismatch, 1);

        // Overflow and drop, then simultaneous push/pop while full
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle_until(30, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_overflow", overflow, 1);
        check("t4_head", ev_ts, 30);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_pushpop_head", ev_ts, 31);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_drained", ev_valid, 0);

        // Counter saturation
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("t5_mealy_sat", mealy_cnt, 255);
        check("t5_moore_sat", moore_cnt, 255);
        check("t5_mismatch", mismatch, 0);

        // Randomised traffic
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            bit m, mo, rdy, c;
            m   = ($urandom % 3) == 0;
            mo  = m_prev ? (($urandom % 16) != 0) : (($urandom % 32) == 0);
            rdy = ($urandom % 2) == 0;
            c   = ($urandom % 100) == 0;
            step(m, mo, rdy, c);
        end

        // Asynchronous reset with three entries pending
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_pending", ev_valid, 1);
        dout_mealy = 1'b0; dout_moore = 1'b0; ev_ready = 1'b0; clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t6_valid", ev_valid, 0);
        check("t6_ev_ts", ev_ts, 0);
        check("t6_mealy_cnt", mealy_cnt, 0);
        check("t6_moore_cnt", moore_cnt, 0);
        check("t6_mismatch", mismatch, 0);
        check("t6_overflow", overflow, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 20; i++) step(($urandom % 2) == 0, m_prev, 1'b1, 1'b0);

        // Timestamp wrap on the 4-bit instance: pulses at ts=15 and ts=0
        mon_en = 1'b0;
        @(posedge clk);
        #1 rst_w = 1'b1;
        for (int k = 0; k < 17; k++) begin
            w_mealy = (k == 15) || (k == 16);
            @(posedge clk);
            #1;
        end
        w_mealy = 1'b0;
        check("wrap_valid", w_valid, 1);
        check("wrap_first", w_ts, 15);
        w_ready = 1'b1;
        @(posedge clk);
        #1;
        check("wrap_second_valid", w_valid, 1);
        check("wrap_second", w_ts, 0);
        @(posedge clk);
        #1;
        w_ready = 1'b0;
        check("wrap_empty", w_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
